// File: rtl/gpsdo_discipline_ctrl.sv
// GPSDO discipline loop: outlier-filtered phase averaging, saturated proportional
// PWM correction, lock detection and a 4-byte status frame to the UART.
module gpsdo_discipline_ctrl #(
  parameter logic [23:0] TARGET    = 24'd50,
  parameter int          AVG_LOG2  = 3,
  parameter int          KP_SHIFT  = 2,
  parameter logic [23:0] OUTLIER   = 24'd1000,
  parameter int          LOCK_TOL  = 4,
  parameter int          LOCK_CNT  = 4,
  parameter logic [15:0] DUTY_INIT = 16'd32768,
  parameter logic [15:0] DUTY_MIN  = 16'd1024,
  parameter logic [15:0] DUTY_MAX  = 16'd64511
) (
  input  logic        CLK_Sys,
  input  logic        CLK_Rst,
  input  logic        GPS_Exist,
  input  logic        phase_valid,
  input  logic [23:0] phase_cnt,
  input  logic        uart_ready,
  output logic        uart_en,
  output logic [7:0]  data,
  output logic [15:0] PWM_Duty,
  output logic [24:0] phase_mean,
  output logic        locked,
  output logic [7:0]  reject_cnt
);

  localparam int SW = 25 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] LAST_SAMP = CW'(2**AVG_LOG2 - 1);
  localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_CNT);

  typedef enum logic [1:0] {S_HOLD, S_ACCUM, S_UPDATE, S_REPORT} state_t;

  state_t                r_state;
  logic signed [SW-1:0]  r_sum;
  logic [CW-1:0]         r_cnt;
  logic [GW-1:0]         r_good;
  logic [1:0]            r_byte;

  logic signed [24:0]    w_err;
  logic [24:0]           w_err_abs;
  logic                  w_reject;
  logic signed [SW-1:0]  w_sum_next;
  logic signed [24:0]    w_mean;
  logic [24:0]           w_mean_abs;
  logic signed [24:0]    w_corr;
  logic signed [26:0]    w_next;
  logic [15:0]           w_duty;
  logic                  w_good;

  assign w_err      = $signed({1'b0, phase_cnt}) - $signed({1'b0, TARGET});
  assign w_err_abs  = w_err[24] ? 25'(-w_err) : 25'(w_err);
  assign w_reject   = w_err_abs > {1'b0, OUTLIER};
  assign w_sum_next = r_sum + SW'(w_err);
  assign w_mean     = 25'(r_sum >>> AVG_LOG2);
  assign w_mean_abs = w_mean[24] ? 25'(-w_mean) : 25'(w_mean);
  assign w_corr     = w_mean >>> KP_SHIFT;
  assign w_next     = $signed({11'b0, PWM_Duty}) - 27'(w_corr);
  assign w_good     = w_mean_abs <= 25'(LOCK_TOL);

  // Clamp the corrected duty word into the VCXO's usable tuning range.
  always_comb begin
    w_duty = w_next[15:0];
    if (w_next < $signed({11'b0, DUTY_MIN})) begin
      w_duty = DUTY_MIN;
    end else if (w_next > $signed({11'b0, DUTY_MAX})) begin
      w_duty = DUTY_MAX;
    end else begin
      w_duty = w_next[15:0];
    end
  end

  // Discipline FSM; losing GPS overrides every state and abandons any frame.
  always_ff @(posedge CLK_Sys or posedge CLK_Rst) begin
    if (CLK_Rst) begin
      r_state    <= S_HOLD;
      r_sum      <= '0;
      r_cnt      <= '0;
      r_good     <= '0;
      r_byte     <= 2'd0;
      PWM_Duty   <= DUTY_INIT;
      uart_en    <= 1'b0;
      data       <= 8'h00;
      phase_mean <= 25'd0;
      locked     <= 1'b0;
      reject_cnt <= 8'd0;
    end else if (!GPS_Exist) begin
      r_state <= S_HOLD;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_good  <= '0;
      locked  <= 1'b0;
      uart_en <= 1'b0;
    end else begin
      case (r_state)
        S_HOLD: begin
          r_sum   <= '0;
          r_cnt   <= '0;
          r_state <= S_ACCUM;
        end
        S_ACCUM: begin
          if (phase_valid) begin
            if (w_reject) begin
              if (reject_cnt != 8'hFF) reject_cnt <= reject_cnt + 8'd1;
            end else begin
              r_sum <= w_sum_next;
              r_cnt <= r_cnt + CW'(1);
              if (r_cnt == LAST_SAMP) r_state <= S_UPDATE;
            end
          end
        end
        S_UPDATE: begin
          PWM_Duty   <= w_duty;
          phase_mean <= w_mean;
          if (w_good) begin
            if (r_good != GOOD_MAX) r_good <= r_good + GW'(1);
            locked <= (r_good >= GOOD_MAX - GW'(1));
          end else begin
            r_good <= '0;
            locked <= 1'b0;
          end
          r_sum   <= '0;
          r_cnt   <= '0;
          uart_en <= 1'b1;
          data    <= 8'hA5;
          r_byte  <= 2'd0;
          r_state <= S_REPORT;
        end
        S_REPORT: begin
          // uart_en is high for the whole state, so uart_ready alone marks a transfer.
          if (uart_ready) begin
            case (r_byte)
              2'd0:    data <= PWM_Duty[15:8];
              2'd1:    data <= PWM_Duty[7:0];
              2'd2:    data <= phase_mean[7:0];
              default: data <= data;
            endcase
            if (r_byte == 2'd3) begin
              uart_en <= 1'b0;
              r_state <= S_ACCUM;
            end else begin
              r_byte <= r_byte + 2'd1;
            end
          end
        end
        default: r_state <= S_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_gpsdo_discipline_ctrl.sv
// Self-checking bench: directed window table, multi-cycle corner sequences and
// randomized traffic against a window-level reference model.
module tb_gpsdo_discipline_ctrl;

  logic        clk = 1'b0;
  logic        rst, gps, pv, rdy;
  logic [23:0] pc;
  logic        uen [2];
  logic [7:0]  dat [2];
  logic [15:0] duty [2];
  logic [24:0] pmean [2];
  logic        lck [2];
  logic [7:0]  rej [2];

  always #50 clk = ~clk;

  gpsdo_discipline_ctrl u_dut (
    .CLK_Sys(clk), .CLK_Rst(rst), .GPS_Exist(gps), .phase_valid(pv), .phase_cnt(pc),
    .uart_ready(rdy), .uart_en(uen[0]), .data(dat[0]), .PWM_Duty(duty[0]),
    .phase_mean(pmean[0]), .locked(lck[0]), .reject_cnt(rej[0]));

  gpsdo_discipline_ctrl #(.DUTY_MIN(16'd32700), .DUTY_MAX(16'd32780)) u_clamp (
    .CLK_Sys(clk), .CLK_Rst(rst), .GPS_Exist(gps), .phase_valid(pv), .phase_cnt(pc),
    .uart_ready(rdy), .uart_en(uen[1]), .data(dat[1]), .PWM_Duty(duty[1]),
    .phase_mean(pmean[1]), .locked(lck[1]), .reject_cnt(rej[1]));

  int checks = 0;
  int failures = 0;

  // Reference model: 0 hold, 1 accumulate, 2 update pending, 3 reporting
  int m_mode, m_sum, m_n, m_rej, m_good, m_locked, m_mean, m_idx;
  int m_duty [2];
  int m_frame [2][4];
  int lo [2] = '{1024, 32700};
  int hi [2] = '{64511, 32780};

  function automatic int fdiv(int a, int b);
    int q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int iabs(int a);
    return (a < 0) ? -a : a;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_sum = 0; m_n = 0; m_rej = 0; m_good = 0; m_locked = 0;
    m_mean = 0; m_idx = 0; m_duty[0] = 32768; m_duty[1] = 32768;
  endtask

  task automatic model_step();
    int e, corr;
    if (rst) begin
      model_reset();
    end else if (!gps) begin
      m_mode = 0; m_sum = 0; m_n = 0; m_good = 0; m_locked = 0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: if (pv) begin
          e = int'(pc) - 50;
          if (iabs(e) > 1000) begin
            if (m_rej < 255) m_rej++;
          end else begin
            m_sum += e;
            m_n++;
            if (m_n == 8) m_mode = 2;
          end
        end
        2: begin
          m_mean = fdiv(m_sum, 8);
          corr = fdiv(m_mean, 4);
          for (int k = 0; k < 2; k++) begin
            m_duty[k] = m_duty[k] - corr;
            if (m_duty[k] < lo[k]) m_duty[k] = lo[k];
            if (m_duty[k] > hi[k]) m_duty[k] = hi[k];
            m_frame[k][0] = 'hA5;
            m_frame[k][1] = m_duty[k] / 256;
            m_frame[k][2] = m_duty[k] % 256;
            m_frame[k][3] = m_mean & 'hFF;
          end
          if (iabs(m_mean) <= 4) m_good = (m_good < 4) ? m_good + 1 : 4;
          else m_good = 0;
          m_locked = (m_good == 4);
          m_sum = 0; m_n = 0; m_idx = 0; m_mode = 3;
        end
        3: if (rdy) begin
          m_idx++;
          if (m_idx == 4) m_mode = 1;
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk("uart_en", int'(uen[k]), (m_mode == 3) ? 1 : 0);
      if (m_mode == 3) chk("data", int'(dat[k]), m_frame[k][m_idx]);
      chk("pwm_duty", int'(duty[k]), m_duty[k]);
      chk("phase_mean", int'($signed(pmean[k])), m_mean);
      chk("locked", int'(lck[k]), m_locked);
      chk("reject_cnt", int'(rej[k]), m_rej);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; gps = 1'b1; pv = 1'b0; pc = 24'd0; rdy = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic strobe(int p);
    pv = 1'b1; pc = 24'(p);
    tick();
    pv = 1'b0;
    tick();
  endtask

  task automatic finish_frame(output int hs);
    int b = 0;
    hs = 0;
    while (m_mode != 1 && b < 300) begin
      if (uen[0] && rdy) hs++;
      tick();
      b++;
    end
    chk("frame_timeout", (b < 300) ? 1 : 0, 1);
  endtask

  typedef struct {
    int phase;
    int exp_duty;
    int exp_duty_c;
    int exp_mean;
  } vec_t;

  vec_t vecs [6];
  int hs;
  logic [7:0] held;
  int r;

  initial begin
    vecs[0] = '{58,   32766, 32766,    8};
    vecs[1] = '{42,   32770, 32770,   -8};
    vecs[2] = '{1000, 32531, 32700,  950};
    vecs[3] = '{50,   32768, 32768,    0};
    vecs[4] = '{0,    32781, 32780,  -50};
    vecs[5] = '{1050, 32518, 32700, 1000};

    // Immediate reset values
    rst = 1'b1; gps = 1'b0; pv = 1'b0; pc = 24'd0; rdy = 1'b1;
    model_reset();
    #20;
    chk("rst_pwm", int'(duty[0]), 32768);
    chk("rst_data", int'(dat[0]), 0);
    chk("rst_uart_en", int'(uen[0]), 0);
    chk("rst_mean", int'(pmean[0]), 0);
    chk("rst_locked", int'(lck[0]), 0);
    chk("rst_reject", int'(rej[0]), 0);

    // Table of single windows from reset
    foreach (vecs[i]) begin
      do_reset();
      for (int s = 0; s < 8; s++) strobe(vecs[i].phase);
      chk("tbl_uart_en", int'(uen[0]), 1);
      chk("tbl_a5", int'(dat[0]), 'hA5);
      chk("tbl_duty", int'(duty[0]), vecs[i].exp_duty);
      chk("tbl_duty_clamp", int'(duty[1]), vecs[i].exp_duty_c);
      chk("tbl_mean", int'($signed(pmean[0])), vecs[i].exp_mean);
      tick();
      chk("tbl_b1", int'(dat[0]), vecs[i].exp_duty / 256);
      tick();
      chk("tbl_b2", int'(dat[0]), vecs[i].exp_duty % 256);
      tick();
      chk("tbl_b3", int'(dat[0]), vecs[i].exp_mean & 'hFF);
      tick();
      chk("tbl_done", int'(uen[0]), 0);
    end

    // Outlier discarded: window closes only on the 9th strobe
    do_reset();
    for (int s = 0; s < 7; s++) strobe(58);
    strobe(5000);
    chk("outl_no_update", int'(uen[0]), 0);
    chk("outl_reject", int'(rej[0]), 1);
    strobe(58);
    chk("outl_update", int'(uen[0]), 1);
    chk("outl_mean", int'($signed(pmean[0])), 8);
    finish_frame(hs);
    chk("outl_handshakes", hs, 4);

    // GPS loss mid-window discards the partial window
    do_reset();
    for (int s = 0; s < 5; s++) strobe(58);
    gps = 1'b0;
    tick(); tick(); tick();
    gps = 1'b1;
    tick();
    for (int s = 0; s < 7; s++) strobe(58);
    chk("gps_no_update", int'(uen[0]), 0);
    chk("gps_pwm_frozen", int'(duty[0]), 32768);
    strobe(58);
    chk("gps_update", int'(uen[0]), 1);
    chk("gps_locked", int'(lck[0]), 0);
    finish_frame(hs);

    // Lock acquisition with stalled UART, then loss of lock
    do_reset();
    for (int w = 0; w < 5; w++) begin
      for (int s = 0; s < 8; s++) strobe((w == 4) ? 58 : 52);
      chk("lock_state", int'(lck[0]), (w == 3) ? 1 : 0);
      rdy = 1'b0;
      held = dat[0];
      for (int c = 0; c < 10; c++) begin
        tick();
        chk("stall_en", int'(uen[0]), 1);
        chk("stall_data", int'(dat[0]), int'(held));
      end
      rdy = 1'b1;
      finish_frame(hs);
      chk("lock_handshakes", hs, 4);
    end

    // Reset asserted mid-frame returns immediately to reset values
    for (int s = 0; s < 8; s++) strobe(1000);
    tick();
    rst = 1'b1;
    #5;
    chk("midrst_en", int'(uen[0]), 0);
    chk("midrst_pwm", int'(duty[0]), 32768);
    chk("midrst_data", int'(dat[0]), 0);
    model_reset();
    tick();
    rst = 1'b0;
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 6000; c++) begin
      pv = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 99);
      if (r < 65)      pc = 24'(30 + $urandom_range(0, 40));
      else if (r < 80) pc = 24'($urandom_range(0, 1200));
      else if (r < 88) pc = ($urandom_range(0, 1) == 1) ? 24'd1050 : 24'd1051;
      else if (r < 95) pc = 24'($urandom_range(0, 1100));
      else             pc = 24'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      gps = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpsdo_discipline_ctrl.md
# gpsdo_discipline_ctrl

Closed-loop discipline controller for the GPSDO. It consumes one phase-difference measurement per second (GPS 1PPS to local 1PPS, in CLK_Sys counts), rejects outliers, and averages 2^AVG_LOG2 accepted samples. Each complete window updates the VCXO PWM duty word with a saturated proportional correction and streams a 4-byte status frame to the UART transmitter over a valid/ready handshake. It sits between the phase counter and the PWM generator / UART TX.

## Interface
- TARGET, 24'd50: nominal phase count (zero-error point).
- AVG_LOG2, 3: log2 of samples per window (N = 8).
- KP_SHIFT, 2: correction = mean >>> KP_SHIFT (arithmetic).
- OUTLIER, 24'd1000: sample rejected if |err| > OUTLIER.
- LOCK_TOL, 4: window counts as "good" if |mean| <= LOCK_TOL.
- LOCK_CNT, 4: consecutive good windows needed to assert locked.
- DUTY_INIT, 16'd32768 / DUTY_MIN, 16'd1024 / DUTY_MAX, 16'd64511: duty reset value and clamp limits.
- CLK_Sys  in  1  10 MHz system clock; all logic on rising edge.
- CLK_Rst  in  1  asynchronous, active-high reset.
- GPS_Exist  in  1  GPS present; low forces HOLD.
- phase_valid  in  1  one-cycle strobe, phase_cnt valid.
- phase_cnt  in  24  unsigned GPS-to-local count.
- uart_ready  in  1  UART TX can accept a byte.
- uart_en  out  1  byte valid to UART.
- data  out  8  byte to UART.
- PWM_Duty  out  16  VCXO tuning duty word.
- phase_mean  out  25  signed mean error of last window.
- locked  out  1  loop locked.
- reject_cnt  out  8  outliers rejected, saturates at 255.

## Operation
- err = phase_cnt - TARGET, 25-bit signed (zero-extend phase_cnt first). sum is (25+AVG_LOG2)-bit signed; sample counter is AVG_LOG2+1 bits.
- States: HOLD, ACCUM, UPDATE, REPORT.
- HOLD: sum and count cleared; PWM_Duty frozen; locked = 0; good-window counter cleared. Go to ACCUM when GPS_Exist = 1.
- ACCUM: on phase_valid, if |err| > OUTLIER then reject_cnt++ (saturating) and the sample is discarded; else sum += err, count++. When count reaches N, go to UPDATE. GPS_Exist = 0 in any state -> HOLD next edge (an in-flight frame is abandoned, uart_en dropped).
- UPDATE (1 cycle): mean = sum >>> AVG_LOG2; corr = mean >>> KP_SHIFT; next = PWM_Duty - corr, computed in 27-bit signed, clamped to [DUTY_MIN, DUTY_MAX]. Register PWM_Duty and phase_mean. If |mean| <= LOCK_TOL, increment the good counter (saturate at LOCK_CNT), else clear it; locked = (good count == LOCK_CNT). Clear sum/count. Go to REPORT.
- REPORT: send bytes 0xA5, PWM_Duty[15:8], PWM_Duty[7:0], phase_mean[7:0], in order. A byte transfers on an edge where uart_en & uart_ready. While uart_ready = 0, uart_en and data are held stable. After the 4th transfer: uart_en = 0, go to ACCUM.
- phase_valid in UPDATE/REPORT/HOLD: ignored (no accumulate, no reject count).

## Timing
- Reset values: PWM_Duty = DUTY_INIT, uart_en = 0, data = 0, phase_mean = 0, locked = 0, reject_cnt = 0; state HOLD.
- Nth accepted sample strobed at edge k: state = UPDATE after k; PWM_Duty, phase_mean, locked new after k+1, with uart_en = 1 and data = 0xA5 after k+1.
- With uart_ready held high, bytes transfer at edges k+2..k+5; uart_en = 0 and state = ACCUM after k+5.
- Reset asserted mid-window or mid-frame: immediate return to reset values; the partial window is lost.

## Test plan
- GPS_Exist=1, 8 strobes phase_cnt=58 (err +8) -> mean 8, corr 2, PWM_Duty 32766; frame A5,7F,FE,08; uart_en high exactly 4 handshake cycles.
- 8 strobes phase_cnt=42 -> mean -8, PWM_Duty 32770; frame A5,80,02,F8.
- DUTY_MIN=32700, 8 strobes phase_cnt=1000 (err 950) -> corr 237, PWM_Duty clamps to 32700 (not 32531).
- 7 strobes at 58, one at 5000 (err 4950), one more at 58 -> reject_cnt=1; UPDATE only after the 9th strobe; mean 8.
- 5 strobes, then GPS_Exist=0 for 3 cycles, then 1 -> PWM_Duty unchanged; a full 8 new strobes are needed before UPDATE; locked=0.
- 4 windows at phase_cnt=52 (mean 2) with uart_ready low for 10 cycles during each frame -> data/uart_en stable while stalled; locked rises after the 4th UPDATE; a 5th window at mean 8 drops locked.
